// File: rtl/mc_pkg.sv
// Shared types and constants for the Monte Carlo path replay buffer.
// Holds the sequencer state encoding and checksum width.
package mc_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_STREAM,
    S_WAIT_RS,
    S_DONE
  } state_t;

  localparam int DEF_DW    = 12;
  localparam int DEF_DEPTH = 256;
  localparam int CKW       = 16;

endpackage

// File: rtl/mc_path_replay_buffer_if.sv
// Sample in/out handshake bundle of the path replay buffer.
// master drives samples and out_ready; slave is the buffer.
interface mc_path_replay_buffer_if
  import mc_pkg::*;
#(
  parameter int DW = DEF_DW
);
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          out_last;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/mc_replay_chk.sv
// Replay consistency checker: per-pass 16-bit sum compared with pass 0.
// Only instantiated when MC_REPLAY_CHECK_EN is defined.
module mc_replay_chk
  import mc_pkg::*;
#(
  parameter int DW = DEF_DW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr_err,
  input  logic          clr_acc,
  input  logic          fire,
  input  logic          last,
  input  logic          first_pass,
  input  logic [DW-1:0] data,
  output logic          chk_err
);
  logic [CKW-1:0] acc;
  logic [CKW-1:0] ref_sum;
  logic [CKW-1:0] sum;
  logic           end_hs;

  assign sum    = acc + CKW'(data);
  assign end_hs = fire & last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc     <= '0;
      ref_sum <= '0;
      chk_err <= 1'b0;
    end else begin
      if (clr_acc) acc <= '0;
      else if (fire) acc <= sum;
      if (end_hs && first_pass) ref_sum <= sum;
      if (clr_err) chk_err <= 1'b0;
      else if (end_hs && !first_pass && sum != ref_sum)
        chk_err <= 1'b1;
    end
  end
endmodule

// File: rtl/mc_path_replay_buffer.sv
// Loads DEPTH samples per day, replays them PASSES times, for DAYS days.
// Optional replay checker enabled by MC_REPLAY_CHECK_EN.
module mc_path_replay_buffer
  import mc_pkg::*;
#(
  parameter  int DW     = DEF_DW,
  parameter  int DEPTH  = DEF_DEPTH,
  parameter  int PASSES = 2,
  parameter  int DAYS   = 8,
  localparam int PW     = $clog2(PASSES + 1),
  localparam int YW     = $clog2(DAYS + 1)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    resend,
  mc_path_replay_buffer_if.slave  bus,
  output logic [PW-1:0]           pass_idx,
  output logic [YW-1:0]           day_idx,
  output logic                    busy,
  output logic                    all_done,
  output logic                    chk_err
);
  localparam int AW = $clog2(DEPTH);

  state_t        state, state_n;
  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW:0]   rptr;
  logic          in_fire, wlast;
  logic          out_fire, last_fire;
  logic          reload, go;
  logic          pass_more, day_more;
  logic          stream_entry;

  assign bus.in_ready = (state == S_LOAD);
  assign busy     = (state != S_IDLE) && (state != S_DONE);
  assign all_done = (state == S_DONE);

  assign in_fire   = bus.in_valid & bus.in_ready;
  assign wlast     = in_fire & (wptr == AW'(DEPTH - 1));
  assign out_fire  = bus.out_valid & bus.out_ready;
  assign last_fire = out_fire & bus.out_last;
  assign go        = start & ((state == S_IDLE) | (state == S_DONE));
  assign pass_more = int'(pass_idx) < PASSES - 1;
  assign day_more  = int'(day_idx) < DAYS - 1;

  // rptr counts issued samples; reaching DEPTH stops further reloads
  assign reload = (state == S_STREAM)
                & (!bus.out_valid | bus.out_ready)
                & (rptr < (AW+1)'(DEPTH));

  assign stream_entry = (state_n == S_STREAM) && (state != S_STREAM);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE, S_DONE: if (start) state_n = S_LOAD;
      S_LOAD:    if (wlast) state_n = S_STREAM;
      S_STREAM:  if (last_fire) state_n = S_WAIT_RS;
      S_WAIT_RS: begin
        if (resend)
          state_n = pass_more ? S_STREAM :
                    day_more  ? S_LOAD   : S_DONE;
      end
      default:   state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (in_fire) mem[wptr] <= bus.in_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr         <= '0;
      rptr         <= '0;
      pass_idx     <= '0;
      day_idx      <= '0;
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_last  <= 1'b0;
    end else begin
      if (go) begin
        day_idx  <= '0;
        pass_idx <= '0;
        wptr     <= '0;
      end
      if (in_fire) wptr <= wlast ? '0 : wptr + AW'(1);
      if (state != S_STREAM) rptr <= '0;
      else if (reload) rptr <= rptr + (AW+1)'(1);
      if (reload) begin
        bus.out_valid <= 1'b1;
        bus.out_data  <= mem[rptr[AW-1:0]];
        bus.out_last  <= (rptr == (AW+1)'(DEPTH - 1));
      end else if (out_fire) begin
        bus.out_valid <= 1'b0;
        bus.out_last  <= 1'b0;
      end
      if (state == S_WAIT_RS && resend) begin
        if (pass_more) begin
          pass_idx <= pass_idx + PW'(1);
        end else if (day_more) begin
          day_idx  <= day_idx + YW'(1);
          pass_idx <= '0;
          wptr     <= '0;
        end
      end
    end
  end

`ifdef MC_REPLAY_CHECK_EN
  logic first_pass;
  assign first_pass = (pass_idx == '0);

  mc_replay_chk #(.DW(DW)) u_chk (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr_err    (go),
    .clr_acc    (stream_entry),
    .fire       (out_fire),
    .last       (bus.out_last),
    .first_pass (first_pass),
    .data       (bus.out_data),
    .chk_err    (chk_err)
  );
`else
  assign chk_err = 1'b0;
`endif
endmodule

// File: tb/tb_mc_path_replay_buffer.sv
// Self-checking bench: cycle table, reset sequence, randomized runs.
// Corruption test active when MC_REPLAY_CHECK_EN is defined.
module tb_mc_path_replay_buffer;
  localparam int DW = 12, DEPTH = 4, PASSES = 2, DAYS = 2;
  localparam int PW = $clog2(PASSES + 1);
  localparam int YW = $clog2(DAYS + 1);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic resend = 1'b0;
  logic [PW-1:0] pass_idx;
  logic [YW-1:0] day_idx;
  logic busy, all_done, chk_err;
  int n_chk = 0;
  int n_fail = 0;

  mc_path_replay_buffer_if #(.DW(DW)) bus ();

  mc_path_replay_buffer #(
    .DW(DW), .DEPTH(DEPTH), .PASSES(PASSES), .DAYS(DAYS)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .resend   (resend),
    .bus      (bus),
    .pass_idx (pass_idx),
    .day_idx  (day_idx),
    .busy     (busy),
    .all_done (all_done),
    .chk_err  (chk_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit st, iv, ordy, rs;
    logic [DW-1:0] id;
    bit inr, ov, ol, bsy, dn;
    logic [DW-1:0] od;
    int p, d;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic timeout(input string nm);
    n_chk++;
    n_fail++;
    $display("FAIL %s: cycle budget expired", nm);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] s(input int d, input int k);
    return DW'(d * 16 + k + 1);
  endfunction

  function automatic void add(
    input bit st, iv, input logic [DW-1:0] id, input bit ordy, rs,
    input bit inr, ov, input logic [DW-1:0] od, input bit ol,
    input int p, d, input bit bsy, dn);
    vec_t v;
    v.st = st; v.iv = iv; v.id = id; v.ordy = ordy; v.rs = rs;
    v.inr = inr; v.ov = ov; v.od = od; v.ol = ol;
    v.p = p; v.d = d; v.bsy = bsy; v.dn = dn;
    tbl.push_back(v);
  endfunction

  task automatic check_zero(input string nm);
    chk({nm, "_inr"}, 32'(bus.in_ready), 0);
    chk({nm, "_ov"}, 32'(bus.out_valid), 0);
    chk({nm, "_od"}, 32'(bus.out_data), 0);
    chk({nm, "_ol"}, 32'(bus.out_last), 0);
    chk({nm, "_pass"}, 32'(pass_idx), 0);
    chk({nm, "_day"}, 32'(day_idx), 0);
    chk({nm, "_busy"}, 32'(busy), 0);
    chk({nm, "_done"}, 32'(all_done), 0);
    chk({nm, "_err"}, 32'(chk_err), 0);
  endtask

  task automatic run(input int sp, input bit early, input bit corrupt);
    logic [DW-1:0] q[$];
    logic [DW-1:0] held;
    bit stall;
    int k, j, cyc;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("run_load", 32'(bus.in_ready), 1);
    chk("run_err_clr", 32'(chk_err), 0);
    for (int d = 0; d < DAYS; d++) begin
      q.delete();
      for (int i = 0; i < DEPTH; i++) q.push_back(DW'($urandom));
      k = 0;
      cyc = 0;
      while (k < DEPTH && cyc < 200) begin
        chk("ld_inr", 32'(bus.in_ready), 1);
        chk("ld_ov", 32'(bus.out_valid), 0);
        bus.in_valid = ($urandom_range(99) >= sp);
        bus.in_data = bus.in_valid ? q[k] : DW'($urandom);
        if (bus.in_valid) k++;
        step();
        cyc++;
      end
      bus.in_valid = 1'b0;
      if (k < DEPTH) timeout("ld_budget");
      chk("ld_end_inr", 32'(bus.in_ready), 0);
      chk("ld_day", 32'(day_idx), d);
      for (int p = 0; p < PASSES; p++) begin
        j = 0;
        cyc = 0;
        stall = 1'b0;
        held = '0;
        while (j < DEPTH && cyc < 200) begin
          if (stall) begin
            chk("bp_ov", 32'(bus.out_valid), 1);
            chk("bp_hold", 32'(bus.out_data), 32'(held));
          end
          bus.out_ready = ($urandom_range(99) >= sp);
          resend = early && (cyc == 1);
          if (bus.out_valid && bus.out_ready) begin
            chk("st_data", 32'(bus.out_data), 32'(q[j]));
            chk("st_last", 32'(bus.out_last), 32'(j == DEPTH - 1));
            chk("st_pass", 32'(pass_idx), p);
            j++;
          end
          stall = bus.out_valid && !bus.out_ready;
          held = bus.out_data;
          step();
          cyc++;
        end
        resend = 1'b0;
        bus.out_ready = 1'b0;
        if (j < DEPTH) timeout("st_budget");
        chk("wt_ov", 32'(bus.out_valid), 0);
        chk("wt_busy", 32'(busy), 1);
        chk("wt_err", 32'(chk_err), 32'(corrupt && (d > 0 || p > 0)));
`ifdef MC_REPLAY_CHECK_EN
        if (corrupt && d == 0 && p == 0) begin
          q[2] = ~q[2];
          dut.mem[2] = q[2];
        end
`endif
        repeat ($urandom_range(3)) step();
        chk("wt_hold_pass", 32'(pass_idx), p);
        resend = 1'b1;
        step();
        resend = 1'b0;
        if (p < PASSES - 1) begin
          chk("rs_pass", 32'(pass_idx), p + 1);
        end else if (d < DAYS - 1) begin
          chk("rs_day", 32'(day_idx), d + 1);
          chk("rs_pass0", 32'(pass_idx), 0);
        end
      end
    end
    chk("run_done", 32'(all_done), 1);
    chk("run_busy", 32'(busy), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.out_ready = 1'b0;
    #2;
    check_zero("rst");
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // cycle-exact table: 2 days x 2 passes with stalls and stray inputs
    add(1, 1, 'hEEE, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0);
    for (int d = 0; d < DAYS; d++) begin
      for (int k = 0; k < DEPTH; k++)
        add(0, 1, s(d, k), 0, 0, k < DEPTH - 1, 0, 0, 0, 0, d, 1, 0);
      for (int p = 0; p < PASSES; p++) begin
        for (int i = 0; i < DEPTH; i++) begin
          add(d == 0 && p == 1 && i == 2, 1, 'hEEE, 1,
              d == 0 && p == 0 && i == 2,
              0, 1, s(d, i), i == DEPTH - 1, p, d, 1, 0);
          if (d == 1 && p == 0 && i == 1)
            repeat (3)
              add(0, 1, 'hEEE, 0, 0, 0, 1, s(d, 1), 0, p, d, 1, 0);
        end
        add(0, 1, 'hEEE, 1, 0, 0, 0, 0, 0, p, d, 1, 0);
        add(0, 1, 'hEEE, 1, 0, 0, 0, 0, 0, p, d, 1, 0);
        if (p < PASSES - 1)
          add(0, 1, 'hEEE, 0, 1, 0, 0, 0, 0, p + 1, d, 1, 0);
        else if (d < DAYS - 1)
          add(0, 1, 'hEEE, 0, 1, 1, 0, 0, 0, 0, d + 1, 1, 0);
        else
          add(0, 1, 'hEEE, 0, 1, 0, 0, 0, 0, p, d, 0, 1);
      end
    end
    add(0, 1, 'hEEE, 1, 1, 0, 0, 0, 0, 1, 1, 0, 1);

    for (int i = 0; i < tbl.size(); i++) begin
      start = tbl[i].st;
      resend = tbl[i].rs;
      bus.in_valid = tbl[i].iv;
      bus.in_data = tbl[i].id;
      bus.out_ready = tbl[i].ordy;
      step();
      chk($sformatf("row%0d_inr", i), 32'(bus.in_ready), 32'(tbl[i].inr));
      chk($sformatf("row%0d_ov", i), 32'(bus.out_valid), 32'(tbl[i].ov));
      if (tbl[i].ov) begin
        chk($sformatf("row%0d_od", i), 32'(bus.out_data), 32'(tbl[i].od));
        chk($sformatf("row%0d_ol", i), 32'(bus.out_last), 32'(tbl[i].ol));
      end
      chk($sformatf("row%0d_pass", i), 32'(pass_idx), tbl[i].p);
      chk($sformatf("row%0d_day", i), 32'(day_idx), tbl[i].d);
      chk($sformatf("row%0d_busy", i), 32'(busy), 32'(tbl[i].bsy));
      chk($sformatf("row%0d_done", i), 32'(all_done), 32'(tbl[i].dn));
      chk($sformatf("row%0d_err", i), 32'(chk_err), 0);
    end
    start = 1'b0;
    resend = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;

    // async reset in the middle of a stream
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      bus.in_valid = 1'b1;
      bus.in_data = DW'(12'h0A1 + k);
      step();
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    step();
    step();
    chk("pre_rst_od", 32'(bus.out_data), 32'h0A2);
    #2;
    rst_n = 1'b0;
    #1;
    check_zero("mid_rst");
    bus.out_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("post_rst_busy", 32'(busy), 0);
    chk("post_rst_inr", 32'(bus.in_ready), 0);
    chk("post_rst_done", 32'(all_done), 0);

    run(0, 1'b0, 1'b0);
    run(40, 1'b1, 1'b0);
    run(25, 1'b1, 1'b0);
`ifdef MC_REPLAY_CHECK_EN
    run(20, 1'b0, 1'b1);
    chk("err_sticky", 32'(chk_err), 1);
    run(20, 1'b0, 1'b0);
`endif
    chk("final_err", 32'(chk_err), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
